// File: rtl/axis_stream_txfifo_v2_if.sv
// AXI4 slave + AXI-Stream master bundle for the TX FIFO.
// slave modport is the FIFO side; master modport is the driver side.
interface axis_stream_txfifo_v2_if #(
  parameter int DW  = 32,
  parameter int AW  = 6,
  parameter int IDW = 1
);
  logic [IDW-1:0]  S_AXI_AWID;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [7:0]      S_AXI_AWLEN;
  logic [2:0]      S_AXI_AWSIZE;
  logic [1:0]      S_AXI_AWBURST;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;

  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WLAST;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;

  logic [IDW-1:0]  S_AXI_BID;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;

  logic [IDW-1:0]  S_AXI_ARID;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [7:0]      S_AXI_ARLEN;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;

  logic [IDW-1:0]  S_AXI_RID;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  logic [DW-1:0]   M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TKEEP;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN,
    input  S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY,
    output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
    output M_AXIS_TVALID,
    input  M_AXIS_TREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN,
    output S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY,
    input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
    input  M_AXIS_TVALID,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/axis_stream_txfifo_v2.sv
// AXI4-slave to AXI-Stream TX FIFO; each write burst becomes one packet.
// Define TXFIFO_PKT_MODE_EN for store-and-forward, else cut-through.
module axis_stream_txfifo_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int FIFO_DEPTH         = 64
) (
  input logic ACLK,
  input logic ARESETN,
  axis_stream_txfifo_v2_if.slave bus
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int KW  = DW / 8;
  localparam int EW  = DW + KW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int IDW = C_S_AXI_ID_WIDTH;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_e;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic [PW:0]   mem_cnt;
  logic [PW:0]   level;
  logic [EW-1:0] out_q;
  logic          out_vld_q;
  logic          full;
  logic          empty;
  logic          wready;
  logic          push;
  logic          pop;
  logic          load;
  logic          tvalid;
  logic [7:0]    pkt_sat;
  logic [31:0]   stat;

  wstate_e        ws_q;
  logic           awready_q;
  logic           bvalid_q;
  logic [IDW-1:0] bid_q;
  logic [1:0]     bresp_q;
  logic [7:0]     beats_q;
  logic           werr_q;

  rstate_e        rs_q;
  logic           arready_q;
  logic           rvalid_q;
  logic           rlast_q;
  logic [IDW-1:0] rid_q;
  logic [7:0]     rcnt_q;
  logic [DW-1:0]  rdata_q;

  logic unused_ok;
  assign unused_ok = ^{bus.S_AXI_AWADDR, bus.S_AXI_AWSIZE,
                       bus.S_AXI_AWBURST, bus.S_AXI_ARADDR};

  // level counts the head register as well as the buffer
  assign mem_cnt = wr_ptr_q - rd_ptr_q;
  assign level   = mem_cnt + {{PW{1'b0}}, out_vld_q};
  assign full    = level == (PW+1)'(FIFO_DEPTH);
  assign empty   = level == '0;
  assign wready  = (ws_q == W_DATA) && !full;
  assign push    = bus.S_AXI_WVALID && wready;
  assign pop     = tvalid && bus.M_AXIS_TREADY;
  assign load    = (mem_cnt != '0) && (!out_vld_q || pop);

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {bus.S_AXI_WDATA,
                                  bus.S_AXI_WSTRB,
                                  bus.S_AXI_WLAST};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        out_q     <= mem_q[rd_ptr_q[PW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        out_vld_q <= 1'b1;
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
    end
  end

`ifdef TXFIFO_PKT_MODE_EN
  logic [PW:0] pkt_q;
  logic        force_q;
  logic [15:0] pkt_w;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      if ((push && bus.S_AXI_WLAST) && !(pop && out_q[0]))
        pkt_q <= pkt_q + 1'b1;
      else if (!(push && bus.S_AXI_WLAST) && (pop && out_q[0]))
        pkt_q <= pkt_q - 1'b1;
      // a packet larger than the FIFO must leak out or it never completes
      if (pop && out_q[0])
        force_q <= 1'b0;
      else if (full && pkt_q == '0)
        force_q <= 1'b1;
    end
  end

  assign pkt_w   = 16'(pkt_q);
  assign pkt_sat = (pkt_w > 16'd255) ? 8'hFF : pkt_w[7:0];
  assign tvalid  = out_vld_q && ((pkt_q != '0) || force_q);
`else
  assign pkt_sat = 8'h00;
  assign tvalid  = out_vld_q;
`endif

  assign stat = {pkt_sat, 6'd0, full, empty, 16'(level)};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ws_q      <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      beats_q   <= 8'd0;
      werr_q    <= 1'b0;
    end else begin
      unique case (ws_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (bus.S_AXI_AWVALID && awready_q) begin
            awready_q <= 1'b0;
            bid_q     <= bus.S_AXI_AWID;
            beats_q   <= bus.S_AXI_AWLEN;
            werr_q    <= 1'b0;
            ws_q      <= W_DATA;
          end
        end
        W_DATA: begin
          if (push) begin
            if (bus.S_AXI_WLAST) begin
              bresp_q  <= (werr_q || beats_q != 8'd0) ? 2'b10 : 2'b00;
              bvalid_q <= 1'b1;
              ws_q     <= W_RESP;
            end else if (beats_q == 8'd0) begin
              werr_q <= 1'b1;
            end else begin
              beats_q <= beats_q - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bus.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            ws_q      <= W_IDLE;
          end
        end
        default: ws_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rs_q      <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rcnt_q    <= 8'd0;
      rdata_q   <= '0;
    end else begin
      unique case (rs_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (bus.S_AXI_ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= bus.S_AXI_ARID;
            rcnt_q    <= bus.S_AXI_ARLEN;
            rvalid_q  <= 1'b1;
            rlast_q   <= bus.S_AXI_ARLEN == 8'd0;
            rdata_q   <= DW'(stat);
            rs_q      <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.S_AXI_RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rs_q      <= R_IDLE;
            end else begin
              rcnt_q  <= rcnt_q - 8'd1;
              rlast_q <= rcnt_q == 8'd1;
              rdata_q <= DW'(stat);
            end
          end
        end
        default: rs_q <= R_IDLE;
      endcase
    end
  end

  assign bus.S_AXI_AWREADY = awready_q;
  assign bus.S_AXI_WREADY  = wready;
  assign bus.S_AXI_BID     = bid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_ARREADY = arready_q;
  assign bus.S_AXI_RID     = rid_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.S_AXI_RRESP   = 2'b00;
  assign bus.S_AXI_RLAST   = rlast_q;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.M_AXIS_TDATA  = out_q[EW-1 -: DW];
  assign bus.M_AXIS_TKEEP  = out_q[KW:1];
  assign bus.M_AXIS_TLAST  = out_q[0];
  assign bus.M_AXIS_TVALID = tvalid;
endmodule

// File: doc/axis_stream_txfifo_v2.md
# axis_stream_txfifo_v2

Parametrised AXI4-slave-to-AXI-Stream transmit FIFO. An AXI4 master writes data bursts into the FIFO, and the FIFO drains them onto an AXI-Stream master port; each write burst becomes one stream packet, delimited by TLAST. The AXI4 read channel returns a live status word (level, empty, full, packet count) in place of memory read-back. It sits between the PS/interconnect AXI4 master and downstream stream consumers. This block supersedes the fixed-width, fixed-depth TX FIFO.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width of AXI4 and AXIS; must be 32, 64 or 128.
- C_S_AXI_ADDR_WIDTH, 6, AXI4 address width; addresses are ignored.
- C_S_AXI_ID_WIDTH, 1, AXI4 ID width.
- FIFO_DEPTH, 64, number of entries; power of two, 4..4096.
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  in  per AXI4  write address; only ID, LEN and VALID are used.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_W{DATA,STRB,LAST,VALID}  in  DW, DW/8, 1, 1  write data.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_B{ID,RESP,VALID}  out  IDW, 2, 1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_AR{ID,ADDR,LEN,VALID}  in  per AXI4  read address; ADDR is ignored.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_R{ID,DATA,RESP,LAST,VALID}  out  per AXI4  status read-back.
- S_AXI_RREADY  in  1  read data ready.
- M_AXIS_TDATA  out  DW  stream data.
- M_AXIS_TKEEP  out  DW/8  byte qualifiers, taken from the stored WSTRB.
- M_AXIS_TLAST  out  1  end of packet, taken from the stored WLAST.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream ready.

## Operation
- FIFO entry: {WDATA, WSTRB, WLAST}. Storage is a circular buffer with pointers one bit wider than log2(FIFO_DEPTH).
- level is 0..FIFO_DEPTH.
  - full = (level == FIFO_DEPTH).
  - empty = (level == 0).
- Write FSM states:
  - W_IDLE: AWREADY=1. An AW handshake captures AWID and AWLEN and moves to W_DATA.
  - W_DATA: WREADY = !full. Each W handshake pushes one entry and decrements a beat counter. The beat carrying WLAST moves to W_RESP.
  - W_RESP: BVALID=1, BID = captured AWID. BREADY moves back to W_IDLE.
- BRESP is OKAY (00) in the normal case.
- BRESP is SLVERR (10) if WLAST arrived on a beat other than AWLEN+1. The data is pushed regardless.
- Only one write burst is outstanding at a time. AWREADY=0 outside W_IDLE.
- Read FSM states:
  - R_IDLE: ARREADY=1. An AR handshake captures ARID and ARLEN.
  - R_DATA: ARLEN+1 beats. RLAST on the final beat. RRESP=OKAY. Return to R_IDLE after the RLAST handshake.
- RDATA is sampled each beat:
  - bits [15:0] = level
  - bit [16] = empty
  - bit [17] = full
  - bits [23:18] = 0
  - bits [31:24] = completed-packet count, saturating at 255
  - bits above 31 = 0
- AXIS pop occurs when TVALID && TREADY.
- The packet count increments on a push with WLAST=1 and decrements on a pop with TLAST=1. Both in the same cycle leaves it unchanged.

## Timing
- Reset:
  - All outputs are 0 while ARESETN is low.
  - AWREADY and ARREADY go to 1 on the first ACLK edge after deassertion.
  - ARESETN low at any time, including mid-burst: pointers, level, packet count and both FSMs clear immediately, and FIFO contents are discarded.
- Latency: a word pushed at edge N is presented on TDATA/TVALID after edge N+1 (registered output, cut-through).
- Full: WREADY deasserts the cycle after level reaches FIFO_DEPTH. A pop in the full cycle re-enables WREADY the next cycle; there is no same-cycle push-through.
- Empty: TVALID=0, and TDATA holds its last value.
- Simultaneous push and pop: level is unchanged and ordering is preserved.
- Pointer wrap: the pointers wrap modulo 2·FIFO_DEPTH, with no bubble.
- TVALID, once high, stays high with stable TDATA/TKEEP/TLAST until TREADY.

## Configuration
- TXFIFO_PKT_MODE_EN defined (store-and-forward):
  - TVALID asserts only while the packet count > 0, i.e. the cycle after the WLAST beat is pushed.
  - Deadlock escape: if full and the packet count == 0, TVALID asserts (forced cut-through) until that packet's TLAST pops.
- TXFIFO_PKT_MODE_EN undefined (cut-through):
  - TVALID = !empty.
  - The packet counter is removed, and RDATA[31:24] reads 0.

## Test plan
- Write an 8-beat INCR burst with data 1..8 and TREADY=1 → AXIS beats 1..8, TLAST on beat 8 only, TKEEP=0xF, BRESP=00.
- Hold TREADY=0 and write FIFO_DEPTH+4 beats with FIFO_DEPTH=64 → WREADY low after 64 beats, level reads 0x40 with full=1; releasing TREADY drains 68 beats in order, and the burst completes.
- Write a burst with AWLEN=3 and WLAST on beat 2 → BRESP=SLVERR, and 2 entries are stored.
- Issue an ARLEN=1 read after pushing 5 beats in packet mode with TREADY=0 → 2 beats of 0x0100_0005, RLAST on the 2nd.
- With TXFIFO_PKT_MODE_EN defined, send an 8-beat burst with a WVALID gap of 10 cycles → TVALID stays 0 until the cycle after beat 8; without the macro, TVALID rises one cycle after beat 1.
- Assert ARESETN low after beat 3 of 8 → all outputs 0; after release, level=0, empty=1, and a new burst is accepted normally.
